// File: rtl/ipm2t_hssthp_txrate_arb.sv
// Round-robin TXCKDIV rate-change scheduler for up to four HSSTHP TX lanes.
// Define TXRATE_ARB_TIMEOUT_EN to abort a lane whose done pulse never arrives.
module ipm2t_hssthp_txrate_arb #(
  parameter int         LANE_NUM        = 4,
  parameter int         FREE_CLOCK_FREQ = 100,
  parameter logic [1:0] P_LX_TX_CKDIV   = 2'b00,
  parameter int         HOLD_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES  = 8 * FREE_CLOCK_FREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANE_NUM-1:0]   i_req,
  input  logic [2*LANE_NUM-1:0] i_req_ckdiv,
  input  logic [LANE_NUM-1:0]   i_txlane_done,
  input  logic [LANE_NUM-1:0]   i_txckdiv_done,
  output logic [LANE_NUM-1:0]   o_tx_rate_chng,
  output logic [2*LANE_NUM-1:0] o_txckdiv,
  output logic [LANE_NUM-1:0]   o_ack,
  output logic [LANE_NUM-1:0]   o_err,
  output logic                  o_busy,
  output logic [1:0]            o_grant_id
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_ACK
  } state_t;

  state_t                state_q, state_d;
  logic [LANE_NUM-1:0]   strb_q, strb_d;
  logic [LANE_NUM-1:0]   ack_q, ack_d;
  logic [LANE_NUM-1:0]   err_q, err_d;
  logic [2*LANE_NUM-1:0] ckdiv_q, ckdiv_d;
  logic                  busy_q, busy_d;
  logic [1:0]            gid_q, gid_d;
  logic [1:0]            last_q, last_d;
  logic [19:0]           cnt_q, cnt_d;

  logic [LANE_NUM-1:0]   elig;
  logic                  found;
  logic [1:0]            pick;

  assign elig = i_req & i_txlane_done;

  // First eligible lane after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int i = 1; i <= LANE_NUM; i++) begin
      int idx;
      idx = (int'(last_q) + i) % LANE_NUM;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = 2'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    strb_d  = '0;
    ack_d   = '0;
    err_d   = '0;
    ckdiv_d = ckdiv_q;
    busy_d  = busy_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q + 20'd1;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          ckdiv_d[2*int'(pick) +: 2] =
            i_req_ckdiv[2*int'(pick) +: 2];
          last_d  = pick;
          gid_d   = pick;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (!i_req[last_q]) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d        = S_ISSUE;
          strb_d[last_q] = 1'b1;
          cnt_d          = '0;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 20'(HOLD_CYCLES - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          strb_d[last_q] = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_txckdiv_done[last_q]) begin
          state_d       = S_ACK;
          ack_d[last_q] = 1'b1;
        end
`ifdef TXRATE_ARB_TIMEOUT_EN
        else if (cnt_q == 20'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_IDLE;
          err_d[last_q] = 1'b1;
          busy_d        = 1'b0;
        end
`endif
      end
      S_ACK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      strb_q  <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      ckdiv_q <= {LANE_NUM{P_LX_TX_CKDIV}};
      busy_q  <= 1'b0;
      gid_q   <= 2'd0;
      last_q  <= 2'(LANE_NUM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ckdiv_q <= ckdiv_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_tx_rate_chng = strb_q;
  assign o_txckdiv      = ckdiv_q;
  assign o_ack          = ack_q;
  assign o_err          = err_q;
  assign o_busy         = busy_q;
  assign o_grant_id     = gid_q;

endmodule

// File: tb/tb_ipm2t_hssthp_txrate_arb.sv
// Scoreboard bench for ipm2t_hssthp_txrate_arb: grant order,
// divider latching, strobe width, abort, timeout and reset.
module tb_ipm2t_hssthp_txrate_arb;
  localparam int HOLD = 4;
  localparam int TMO  = 800;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_req, i_txlane_done, i_txckdiv_done;
  logic [7:0] i_req_ckdiv;
  logic [3:0] o_tx_rate_chng, o_ack, o_err;
  logic [7:0] o_txckdiv;
  logic       o_busy;
  logic [1:0] o_grant_id;

  typedef struct {
    int         lane;
    logic [1:0] ckdiv;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  ipm2t_hssthp_txrate_arb dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_req_ckdiv   (i_req_ckdiv),
    .i_txlane_done (i_txlane_done),
    .i_txckdiv_done(i_txckdiv_done),
    .o_tx_rate_chng(o_tx_rate_chng),
    .o_txckdiv     (o_txckdiv),
    .o_ack         (o_ack),
    .o_err         (o_err),
    .o_busy        (o_busy),
    .o_grant_id    (o_grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int lane, input logic [1:0] ck);
    exp_t e;
    e.lane  = lane;
    e.ckdiv = ck;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Follows one grant from strobe to ack, answering done after dly cycles.
  task automatic serve_one(input int dly, output int lane);
    int   w;
    exp_t e;
    lane = -1;
    w    = 0;
    while (o_tx_rate_chng == 4'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (o_tx_rate_chng == 4'b0) begin
      $display("FAIL strobe_wait: got none want strobe in 40 cycles");
      return;
    end else n_pass++;
    for (int k = 3; k >= 0; k--)
      if (o_tx_rate_chng[k]) lane = k;
    n_chk++;
    if (o_tx_rate_chng !== 4'(1 << lane))
      $display("FAIL strobe_onehot: got %b", o_tx_rate_chng);
    else n_pass++;
    w = 0;
    while (o_tx_rate_chng[lane] && w < 20) begin
      w++;
      @(negedge clk);
    end
    n_chk++;
    if (w != HOLD)
      $display("FAIL strobe_width: got %0d want %0d", w, HOLD);
    else n_pass++;
    repeat (dly) @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b1 || o_ack !== 4'b0)
      $display("FAIL wait_state: busy %b ack %b want 1/0000",
               o_busy, o_ack);
    else n_pass++;
    i_txckdiv_done[lane] = 1'b1;
    @(negedge clk);
    i_txckdiv_done = 4'b0;
    n_chk++;
    if (o_ack !== 4'(1 << lane))
      $display("FAIL ack_pulse: got %b want lane %0d", o_ack, lane);
    else n_pass++;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: got ack on lane %0d want none", lane);
    end else begin
      e = exp_q.pop_front();
      if (lane != e.lane || o_txckdiv[2*lane +: 2] !== e.ckdiv)
        $display("FAIL grant_order: got lane %0d ck %b want lane %0d ck %b",
                 lane, o_txckdiv[2*lane +: 2], e.lane, e.ckdiv);
      else n_pass++;
    end
    i_req[lane] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (o_ack !== 4'b0)
      $display("FAIL ack_width: got %b want 0000", o_ack);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_req          = 4'b0;
    i_req_ckdiv    = 8'b0;
    i_txlane_done  = 4'hf;
    i_txckdiv_done = 4'b0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({o_tx_rate_chng, o_ack, o_err, o_busy, o_grant_id} !== 15'b0)
      $display("FAIL reset_outs: got %b want 0",
               {o_tx_rate_chng, o_ack, o_err, o_busy, o_grant_id});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (o_txckdiv !== 8'b0 || o_busy !== 1'b0)
      $display("FAIL reset_ckdiv: got %b busy %b want 0", o_txckdiv, o_busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int l;
    i_req_ckdiv[5:4] = 2'b10;
    i_req            = 4'b0100;
    push_exp(2, 2'b10);
    @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b1 || o_grant_id !== 2'd2 ||
        o_txckdiv !== 8'b0010_0000 || o_tx_rate_chng !== 4'b0)
      $display("FAIL single_setup: busy %b id %0d ck %b strb %b",
               o_busy, o_grant_id, o_txckdiv, o_tx_rate_chng);
    else n_pass++;
    serve_one(50, l);
    n_chk++;
    if (o_busy !== 1'b0)
      $display("FAIL single_idle: got busy %b want 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int l;
    do_reset();
    i_req_ckdiv = 8'b11_01_10_01;
    i_req       = 4'hf;
    push_exp(0, 2'b01);
    push_exp(1, 2'b10);
    push_exp(2, 2'b01);
    push_exp(3, 2'b11);
    repeat (4) serve_one(2, l);
    n_chk++;
    if (o_txckdiv !== 8'b11_01_10_01)
      $display("FAIL rr_fields: got %b want 11011001", o_txckdiv);
    else n_pass++;
    i_req_ckdiv[1:0] = 2'b10;
    i_req_ckdiv[7:6] = 2'b00;
    i_req            = 4'b1001;
    push_exp(0, 2'b10);
    push_exp(3, 2'b00);
    repeat (2) serve_one(1, l);
    n_chk++;
    if (o_txckdiv !== 8'b00_01_10_10)
      $display("FAIL rr_fields2: got %b want 00011010", o_txckdiv);
    else n_pass++;
  endtask

  task automatic test_not_ready();
    int l;
    i_txlane_done    = 4'b1101;
    i_req_ckdiv[3:2] = 2'b11;
    i_req            = 4'b0010;
    repeat (10) @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b0 || o_tx_rate_chng !== 4'b0)
      $display("FAIL not_ready: got busy %b strb %b want 0",
               o_busy, o_tx_rate_chng);
    else n_pass++;
    i_txlane_done = 4'hf;
    push_exp(1, 2'b11);
    serve_one(3, l);
  endtask

  task automatic test_drop_setup();
    int l;
    i_req_ckdiv[5:4] = 2'b11;
    i_req_ckdiv[7:6] = 2'b01;
    i_req            = 4'b0100;
    @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b1 || o_grant_id !== 2'd2)
      $display("FAIL drop_grant: got busy %b id %0d want 1/2",
               o_busy, o_grant_id);
    else n_pass++;
    i_req = 4'b1000;
    @(negedge clk);
    n_chk++;
    if (o_busy !== 1'b0 || o_tx_rate_chng !== 4'b0 ||
        o_ack !== 4'b0 || o_txckdiv[5:4] !== 2'b11)
      $display("FAIL drop_abort: busy %b strb %b ack %b ck %b",
               o_busy, o_tx_rate_chng, o_ack, o_txckdiv[5:4]);
    else n_pass++;
    push_exp(3, 2'b01);
    serve_one(1, l);
  endtask

  task automatic test_timeout();
    int w;
    int k;
    logic bad;
    i_req_ckdiv[3:2] = 2'b01;
    i_req            = 4'b0010;
    w = 0;
    while (!o_tx_rate_chng[1] && w < 40) begin
      @(negedge clk);
      w++;
    end
    while (o_tx_rate_chng[1] && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (w >= 40)
      $display("FAIL tmo_issue: got %0d cycles want strobe then WAIT", w);
    else n_pass++;
    bad = 1'b0;
`ifdef TXRATE_ARB_TIMEOUT_EN
    k = 0;
    while (!o_err[1] && k < TMO + 50) begin
      if (o_ack != 4'b0) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (k != TMO || o_err !== 4'b0010 || bad)
      $display("FAIL timeout_err: got %0d err %b ack %b want %0d 0010 0",
               k, o_err, bad, TMO);
    else n_pass++;
    i_req = 4'b0;
    @(negedge clk);
    n_chk++;
    if (o_err !== 4'b0 || o_busy !== 1'b0)
      $display("FAIL timeout_idle: got err %b busy %b want 0", o_err, o_busy);
    else n_pass++;
`else
    k = 0;
    repeat (TMO + 200) begin
      if (o_err != 4'b0 || o_ack != 4'b0 || !o_busy) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (bad || o_busy !== 1'b1)
      $display("FAIL no_timeout: got exit after %0d want busy", k);
    else n_pass++;
    i_req = 4'b0;
    do_reset();
`endif
  endtask

  task automatic test_reset_mid();
    int   w;
    logic bad;
    i_req_ckdiv[1:0] = 2'b11;
    i_req            = 4'b0001;
    w = 0;
    while (!o_tx_rate_chng[0] && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    rst   = 1'b1;
    i_req = 4'b0;
    @(negedge clk);
    n_chk++;
    if (o_tx_rate_chng !== 4'b0 || o_busy !== 1'b0 ||
        o_grant_id !== 2'd0 || o_txckdiv !== 8'b0 ||
        o_ack !== 4'b0 || o_err !== 4'b0)
      $display("FAIL reset_mid: strb %b busy %b id %0d ck %b ack %b err %b",
               o_tx_rate_chng, o_busy, o_grant_id, o_txckdiv, o_ack, o_err);
    else n_pass++;
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_tx_rate_chng != 4'b0 || o_ack != 4'b0 || o_err != 4'b0)
        bad = 1'b1;
    end
    n_chk++;
    if (bad || exp_q.size() != 0)
      $display("FAIL post_reset: got activity %b pending %0d want 0 0",
               bad, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_not_ready();
    test_drop_setup();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ipm2t_hssthp_txrate_arb.md
# ipm2t_hssthp_txrate_arb

Round-robin scheduler that serialises TX rate-change (TXCKDIV) requests from up to four HSSTHP TX lanes onto their per-lane TX reset FSMs, so only one lane is ever in its rate-change sequence at a time. It sits between the user or protocol rate-control logic and the TX lane reset FSMs, in the free-running reset clock domain. It drives each lane FSM's rate-change strobe and divider value, then waits for that lane's completion pulse. Optionally it times out a lane that never completes.

## Interface
- LANE_NUM, 4, number of served lanes, 1..4
- FREE_CLOCK_FREQ, 100, free clock in MHz (10..100); scales timeout
- P_LX_TX_CKDIV, 0, 2-bit reset value of every o_txckdiv field
- HOLD_CYCLES, 4, width of the o_tx_rate_chng strobe in clocks, 2..15
- TIMEOUT_CYCLES, 8*FREE_CLOCK_FREQ, WAIT-state limit in clocks, below 2^20

- clk  in  1  free-running reset-domain clock
- rst  in  1  synchronous, active-high reset
- i_req  in  LANE_NUM  level rate-change request per lane
- i_req_ckdiv  in  2*LANE_NUM  requested divider; lane k uses bits [2k+1:2k]
- i_txlane_done  in  LANE_NUM  lane FSM o_txlane_done
- i_txckdiv_done  in  LANE_NUM  lane FSM o_txckdiv_done, one-cycle pulse
- o_tx_rate_chng  out  LANE_NUM  rate-change strobe to lane FSM i_tx_rate_chng
- o_txckdiv  out  2*LANE_NUM  divider to lane FSM i_txckdiv
- o_ack  out  LANE_NUM  one-cycle completion pulse
- o_err  out  LANE_NUM  one-cycle timeout pulse
- o_busy  out  1  a grant is in progress
- o_grant_id  out  2  index of the current or last granted lane

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, ACK.
- Eligible lanes: i_req[k] & i_txlane_done[k], for k < LANE_NUM.
- IDLE:
  - If any lane is eligible, grant the first eligible lane found searching from last_grant+1, wrapping modulo LANE_NUM.
  - Latch i_req_ckdiv of the granted lane into its o_txckdiv field, set last_grant and o_grant_id, go to SETUP.
  - No eligible lane: stay in IDLE.
- SETUP: lasts one cycle so the divider is stable before the strobe.
  - If i_req[g] has dropped, abort to IDLE: no strobe, no ack, o_txckdiv[g] keeps its new value.
  - Otherwise go to ISSUE.
- ISSUE:
  - o_tx_rate_chng[g]=1 for exactly HOLD_CYCLES cycles (hold counter), then go to WAIT.
  - i_req changes are ignored.
- WAIT:
  - i_txckdiv_done[g] sampled high: go to ACK.
  - Done pulses from other lanes are ignored.
  - Timeout handling depends on the configuration macro (see Configuration).
- ACK: o_ack[g]=1 for one cycle, then IDLE. The requester must drop i_req[g] on seeing o_ack.
- Fields of o_txckdiv for non-granted lanes never change.
- o_busy=1 in SETUP, ISSUE, WAIT and ACK.
- Counter: 20-bit, cleared on entry to ISSUE and to WAIT.
- Reset values:
  - o_tx_rate_chng=0, o_ack=0, o_err=0, o_busy=0, o_grant_id=0.
  - o_txckdiv = P_LX_TX_CKDIV replicated across all lanes.
  - last_grant = LANE_NUM-1, so lane 0 has first priority.
  - State = IDLE.
- rst asserted mid-operation: all outputs and state return to reset values at the next edge. The strobe drops immediately; no ack or err is issued.

## Timing
- Request sampled eligible at edge N (state IDLE): SETUP from N+1, with o_busy, o_grant_id and o_txckdiv valid.
- o_tx_rate_chng[g] high for cycles N+2 .. N+1+HOLD_CYCLES.
- WAIT from N+2+HOLD_CYCLES.
- i_txckdiv_done[g] sampled at edge M: o_ack[g] high in cycle M+1, IDLE at M+2.
- Earliest next grant decision is at edge M+2.
- Minimum grant-to-grant spacing: HOLD_CYCLES+4 cycles.

## Configuration
- TXRATE_ARB_TIMEOUT_EN defined:
  - In WAIT, when the counter equals TIMEOUT_CYCLES-1 and i_txckdiv_done[g] is low, pulse o_err[g] for one cycle and return to IDLE. No o_ack is issued.
  - If done and timeout coincide on the same edge, done wins: go to ACK, no o_err.
- TXRATE_ARB_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - o_err is tied to 0 and the timeout compare logic is removed.

## Test plan
- Single request, lane 2, ckdiv=2'b10, done returned 50 cycles into WAIT -> o_txckdiv[5:4]=10 from N+1; strobe for 4 cycles; o_ack[2] one cycle after done; o_busy low afterwards.
- Lanes 0..3 requesting together, each responding with done -> grants in order 0,1,2,3; then lane 0 and lane 3 re-request -> lane 0 is granted first, since lane 3 was last.
- Request on a lane whose i_txlane_done=0 -> no grant until i_txlane_done goes high; then normal sequence.
- Request dropped during SETUP -> no strobe, no ack, return to IDLE; the next eligible lane is granted.
- TXRATE_ARB_TIMEOUT_EN defined, no done from lane 1 -> o_err[1] pulses exactly TIMEOUT_CYCLES cycles after WAIT entry (800 cycles with defaults), no ack; without the macro the block stays busy.
- rst asserted for one cycle mid-ISSUE -> all outputs at reset values next cycle, strobe cut short, o_txckdiv back to P_LX_TX_CKDIV.
